// File: rtl/matmul_seq_pkg.sv
// Shared types and size helpers for the systolic array sequencer.
package matmul_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_CHECK,
        ST_READOUT,
        ST_DONE
    } state_t;

    localparam int unsigned MAX_SIZE_CODE = 4;

    function automatic int unsigned size_to_n(input logic [2:0] code);
        return 32'd2 << code;
    endfunction

    function automatic logic code_valid(input logic [2:0] code, input int unsigned dim);
        return (32'(code) <= MAX_SIZE_CODE) && (size_to_n(code) <= dim);
    endfunction

endpackage

// File: rtl/matmul_seq_readout.sv
// Row-major result grid walker with a valid/ready handshake and last-beat flag.
module matmul_seq_readout #(
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_begin,
    input  logic                 i_rd_ready,
    input  logic [ADDR_BITS-1:0] i_last_idx,
    output logic                 o_rd_valid,
    output logic [ADDR_BITS-1:0] o_row,
    output logic [ADDR_BITS-1:0] o_col,
    output logic                 o_last_fire
);

    logic                 valid_q, valid_d;
    logic [ADDR_BITS-1:0] row_q, row_d;
    logic [ADDR_BITS-1:0] col_q, col_d;
    logic                 fire;
    logic                 at_last;

    assign fire        = valid_q && i_rd_ready;
    assign at_last     = (row_q == i_last_idx) && (col_q == i_last_idx);
    assign o_last_fire = fire && at_last;

    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        col_d   = col_q;
        if (i_begin) begin
            valid_d = 1'b1;
            row_d   = '0;
            col_d   = '0;
        end else if (fire) begin
            if (at_last) begin
                valid_d = 1'b0;
                row_d   = '0;
                col_d   = '0;
            end else if (col_q == i_last_idx) begin
                col_d = '0;
                row_d = row_q + ADDR_BITS'(1);
            end else begin
                col_d = col_q + ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign o_rd_valid = valid_q;
    assign o_row      = row_q;
    assign o_col      = col_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the DIMENSION x DIMENSION systolic PE array: skewed feed,
// finish check and row-major result readout.
module matmul_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int unsigned DIMENSION = 32,
    parameter int unsigned ADDR_BITS = $clog2(DIMENSION),
    parameter int unsigned STEP_BITS = $clog2(3 * DIMENSION)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [2:0]           rf_matrix_size,
    input  logic                 i_src_valid,
    input  logic                 i_array_finish,
    input  logic                 i_rd_ready,
    output logic                 o_pe_valid,
    output logic [DIMENSION-1:0] o_lane_reset,
    output logic [DIMENSION-1:0] o_lane_en,
    output logic [STEP_BITS-1:0] o_step,
    output logic                 o_rd_valid,
    output logic [ADDR_BITS-1:0] o_rd_row,
    output logic [ADDR_BITS-1:0] o_rd_col,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_cfg_err,
    output logic                 o_error
);

    localparam int unsigned LAST_STEP = 3 * DIMENSION - 2;

    state_t               state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [5:0]           n_q, n_d;
    logic [DIMENSION-1:0] lane_reset_q, lane_reset_d;
    logic [DIMENSION-1:0] lane_en_q, lane_en_d;
    logic                 busy_q, done_q, cfg_err_q, error_q;
    logic                 start_ok;
    logic                 rd_begin;
    logic                 rd_last_fire;
    int unsigned          s_int, n_int;

    assign start_ok = (state_q == ST_IDLE) && i_start && code_valid(rf_matrix_size, DIMENSION);
    assign rd_begin = (state_q == ST_CHECK) && i_array_finish;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        n_d     = n_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_FEED;
                    step_d  = '0;
                    n_d     = 6'(size_to_n(rf_matrix_size));
                end
            end
            ST_FEED: begin
                if (i_src_valid) begin
                    if (step_q == STEP_BITS'(LAST_STEP)) begin
                        state_d = ST_CHECK;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_BITS'(1);
                    end
                end
            end
            ST_CHECK:   state_d = i_array_finish ? ST_READOUT : ST_IDLE;
            ST_READOUT: if (rd_last_fire) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Masks are derived from the next step so they line up with o_step in the same cycle.
    always_comb begin
        lane_reset_d = '0;
        lane_en_d    = '0;
        s_int        = 32'(step_d);
        n_int        = 32'(n_d);
        if (state_d == ST_FEED) begin
            for (int unsigned i = 0; i < DIMENSION; i++) begin
                lane_reset_d[i] = (s_int == i);
                lane_en_d[i]    = (i < n_int) && (s_int >= i + 1) && (s_int <= i + n_int);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            n_q          <= '0;
            lane_reset_q <= '0;
            lane_en_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            n_q          <= n_d;
            lane_reset_q <= lane_reset_d;
            lane_en_q    <= lane_en_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            cfg_err_q    <= (state_q == ST_IDLE) && i_start && !code_valid(rf_matrix_size, DIMENSION);
            error_q      <= (state_q == ST_CHECK) && !i_array_finish;
        end
    end

    matmul_seq_readout #(
        .ADDR_BITS (ADDR_BITS)
    ) u_readout (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_begin     (rd_begin),
        .i_rd_ready  (i_rd_ready),
        .i_last_idx  (ADDR_BITS'(n_q - 6'd1)),
        .o_rd_valid  (o_rd_valid),
        .o_row       (o_rd_row),
        .o_col       (o_rd_col),
        .o_last_fire (rd_last_fire)
    );

    // A feed beat is issued exactly when the buffers can supply it.
    assign o_pe_valid   = (state_q == ST_FEED) && i_src_valid;
    assign o_step       = step_q;
    assign o_lane_reset = lane_reset_q;
    assign o_lane_en    = lane_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_cfg_err    = cfg_err_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed and randomized bench for matmul_sequencer with a step/beat reference model.
module tb_matmul_sequencer;

    localparam int unsigned D   = 4;
    localparam int unsigned D8  = 8;
    localparam int unsigned SB  = $clog2(3 * D);
    localparam int unsigned AB  = $clog2(D);
    localparam int unsigned SB8 = $clog2(3 * D8);
    localparam int unsigned AB8 = $clog2(D8);

    logic clk = 1'b0;
    logic rst_n, start, src_valid, finish, rd_ready;
    logic [2:0] code;
    logic rst8, start8;
    logic [2:0] code8;

    logic          pe_valid, rd_valid, busy, done, cfg_err, err;
    logic [D-1:0]  lane_rst, lane_en;
    logic [SB-1:0] step;
    logic [AB-1:0] row, col;

    logic           pe_valid8, rd_valid8, busy8, done8, cfg_err8, err8;
    logic [D8-1:0]  lane_rst8, lane_en8;
    logic [SB8-1:0] step8;
    logic [AB8-1:0] row8, col8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.DIMENSION(D)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .rf_matrix_size(code),
        .i_src_valid(src_valid), .i_array_finish(finish), .i_rd_ready(rd_ready),
        .o_pe_valid(pe_valid), .o_lane_reset(lane_rst), .o_lane_en(lane_en), .o_step(step),
        .o_rd_valid(rd_valid), .o_rd_row(row), .o_rd_col(col), .o_busy(busy),
        .o_done(done), .o_cfg_err(cfg_err), .o_error(err)
    );

    matmul_sequencer #(.DIMENSION(D8)) dut8 (
        .i_clock(clk), .i_reset(rst8), .i_start(start8), .rf_matrix_size(code8),
        .i_src_valid(src_valid), .i_array_finish(finish), .i_rd_ready(rd_ready),
        .o_pe_valid(pe_valid8), .o_lane_reset(lane_rst8), .o_lane_en(lane_en8), .o_step(step8),
        .o_rd_valid(rd_valid8), .o_rd_row(row8), .o_rd_col(col8), .o_busy(busy8),
        .o_done(done8), .o_cfg_err(cfg_err8), .o_error(err8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pe_valid"}, pe_valid, 0);
        chk({tag, "_lane_reset"}, lane_rst, 0);
        chk({tag, "_lane_en"}, lane_en, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_row_col"}, {row, col}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pulses"}, {done, cfg_err, err}, 0);
    endtask

    // src_mode/rd_mode: 0 = always ready, 1 = directed stall, 2 = random
    task automatic run_op(input int unsigned c, input int src_mode, input int rd_mode,
                          input bit fin, input bit mid_start, input int abort_step);
        int unsigned n, s, b, src_stalls, rd_stalls, pe_cnt, dones, beats;
        bit sv, rr;
        logic [D-1:0] e_rst, e_en;
        n = 2 << c;
        s = 0; b = 0; src_stalls = 0; rd_stalls = 0; pe_cnt = 0; dones = 0; beats = 0;
        start = 1'b1;
        code  = 3'(c);
        step_clk();
        start = 1'b0;
        while (s <= 3 * D - 2) begin
            case (src_mode)
                0:       sv = 1'b1;
                1:       sv = !(s == 5 && src_stalls < 3);
                default: sv = ($urandom_range(0, 3) != 0);
            endcase
            if (!sv) src_stalls++;
            src_valid = sv;
            code      = 3'($urandom);
            start     = mid_start && (s == 3);
            if (abort_step >= 0 && int'(s) == abort_step) rst_n = 1'b0;
            e_rst = '0;
            e_en  = '0;
            for (int unsigned i = 0; i < D; i++) begin
                e_rst[i] = (s == i);
                // lane i reads buffer index k = s - i - 1, real operands for k in 0..N-1
                if (i < n && s >= i + 1 && (s - i - 1) < n) e_en[i] = 1'b1;
            end
            @(negedge clk);
            chk("feed_pe_valid", pe_valid, sv);
            chk("feed_step", step, s);
            chk("feed_lane_reset", lane_rst, e_rst);
            chk("feed_lane_en", lane_en, e_en);
            chk("feed_busy", busy, 1);
            chk("feed_rd_valid", rd_valid, 0);
            pe_cnt += 32'(pe_valid);
            step_clk();
            start = 1'b0;
            if (!rst_n) begin
                rst_n     = 1'b1;
                src_valid = 1'b0;
                @(negedge clk);
                check_zero("abort");
                step_clk();
                repeat (40) begin
                    @(negedge clk);
                    dones += 32'(done);
                    step_clk();
                end
                chk("abort_no_done", dones, 0);
                return;
            end
            if (sv) s++;
        end
        chk("feed_pe_count", pe_cnt, 3 * D - 1);

        src_valid = 1'b1;
        finish    = fin;
        @(negedge clk);
        chk("check_pe_valid", pe_valid, 0);
        chk("check_busy", busy, 1);
        chk("check_rd_valid", rd_valid, 0);
        chk("check_error", err, 0);
        step_clk();
        finish    = 1'b0;
        src_valid = 1'b0;
        if (!fin) begin
            @(negedge clk);
            chk("finish_error_pulse", err, 1);
            chk("finish_error_busy", busy, 0);
            step_clk();
            repeat (10) begin
                @(negedge clk);
                beats += 32'(rd_valid);
                step_clk();
            end
            chk("finish_error_no_beats", beats, 0);
            chk("finish_error_cleared", err, 0);
            return;
        end

        while (b < n * n) begin
            case (rd_mode)
                0:       rr = 1'b1;
                1:       rr = !(b == n + 2 && rd_stalls < 2);
                default: rr = ($urandom_range(0, 2) != 0);
            endcase
            if (!rr) rd_stalls++;
            rd_ready  = rr;
            src_valid = 1'($urandom);
            @(negedge clk);
            chk("rd_valid", rd_valid, 1);
            chk("rd_row", row, b / n);
            chk("rd_col", col, b % n);
            chk("rd_pe_valid", pe_valid, 0);
            chk("rd_done_early", done, 0);
            step_clk();
            if (rr) b++;
        end
        rd_ready  = 1'($urandom);
        src_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_rd_valid", rd_valid, 0);
        chk("done_busy", busy, 1);
        step_clk();
        rd_ready = 1'b1;
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("idle_busy", busy, 0);
        step_clk();
    endtask

    task automatic cfg_try(input bit on8, input int unsigned c, input bit exp_err);
        if (on8) begin start8 = 1'b1; code8 = 3'(c); end
        else     begin start  = 1'b1; code  = 3'(c); end
        step_clk();
        start  = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", on8 ? cfg_err8 : cfg_err, exp_err);
        chk("cfg_busy", on8 ? busy8 : busy, !exp_err);
        step_clk();
        @(negedge clk);
        chk("cfg_err_cleared", on8 ? cfg_err8 : cfg_err, 0);
        step_clk();
    endtask

    initial begin
        rst_n = 1'b0; rst8 = 1'b0;
        start = 1'b1; start8 = 1'b1;
        code = 3'd1; code8 = 3'd1;
        src_valid = 1'b1; finish = 1'b0; rd_ready = 1'b1;
        repeat (3) begin
            step_clk();
            @(negedge clk);
            check_zero("reset");
            chk("reset_busy8", busy8, 0);
        end
        step_clk();
        rst_n = 1'b1; rst8 = 1'b1;
        start = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check_zero("idle");
        step_clk();

        cfg_try(1'b0, 5, 1'b1);
        cfg_try(1'b0, 2, 1'b1);
        cfg_try(1'b1, 3, 1'b1);
        cfg_try(1'b1, 5, 1'b1);
        cfg_try(1'b1, 2, 1'b0);
        rst8 = 1'b0;
        step_clk();
        rst8 = 1'b1;
        @(negedge clk);
        chk("dut8_reset_busy", busy8, 0);
        step_clk();

        run_op(1, 0, 0, 1'b1, 1'b0, -1);
        run_op(0, 0, 0, 1'b1, 1'b0, -1);
        run_op(1, 1, 1, 1'b1, 1'b0, -1);
        run_op(1, 0, 0, 1'b0, 1'b0, -1);
        run_op(1, 2, 0, 1'b1, 1'b1, 6);
        run_op(1, 0, 0, 1'b1, 1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            run_op($urandom_range(0, 1), 2, 2, 1'b1, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
